// File: rtl/ps2_pkg.sv
// Shared scan-code constants, decode state type and parity helper for the PS/2 keyboard path.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [3:0] BIT_START = 4'd0;
    localparam logic [3:0] BIT_STOP  = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } ps2_dec_state_t;

    // True when eight data bits plus the parity bit hold an odd number of ones.
    function automatic logic parity_odd(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, ps2_clk glitch filter, 11-bit frame shifter,
// parity/stop check and mid-frame timeout.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 6500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_s;
    logic          data_s;
    logic [FW-1:0] filt_cnt;
    logic          clk_filt;
    logic          clk_filt_d;
    logic          fall;
    logic [3:0]    bit_cnt;
    logic [8:0]    shift;
    logic [TW-1:0] to_cnt;
    logic          stop_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    // The filtered level flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt   <= '0;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
        end else begin
            clk_filt_d <= clk_filt;
            if (clk_s == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt_cnt <= '0;
                clk_filt <= clk_s;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall    = clk_filt_d & ~clk_filt;
    assign stop_ok = data_s & parity_odd(shift);

    // byte_valid is a one-cycle strobe; rx_byte holds that byte until the next strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= BIT_START;
            shift      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                if (bit_cnt == BIT_START) begin
                    if (data_s) begin
                        frame_err <= 1'b1;
                    end else begin
                        bit_cnt <= 4'd1;
                    end
                end else if (bit_cnt == BIT_STOP) begin
                    bit_cnt <= BIT_START;
                    if (stop_ok) begin
                        rx_byte    <= shift[7:0];
                        byte_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    shift   <= {data_s, shift[8:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != BIT_START && to_cnt == TO_LAST) begin
                bit_cnt   <= BIT_START;
                frame_err <= 1'b1;
            end
        end
    end

    // Idle-time watchdog: only runs while a frame is partially received.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (fall || bit_cnt == BIT_START || to_cnt == TO_LAST) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: turns make/break byte sequences into held levels for
// Space, Left arrow and Right arrow.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 6500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic key_space,
    output logic key_left,
    output logic key_right,
    output logic frame_err
);

    logic [7:0]     rx_byte;
    logic           byte_valid;
    ps2_dec_state_t dec_state;
    ps2_dec_state_t dec_state_nx;
    logic           space_nx;
    logic           left_nx;
    logic           right_nx;

    ps2_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_state <= IDLE;
        end else begin
            dec_state <= dec_state_nx;
        end
    end

    // A framing error abandons any half-seen prefix.
    always_comb begin
        dec_state_nx = dec_state;
        if (frame_err) begin
            dec_state_nx = IDLE;
        end else if (byte_valid) begin
            case (dec_state)
                IDLE: begin
                    if (rx_byte == SC_EXT) begin
                        dec_state_nx = EXT;
                    end else if (rx_byte == SC_BREAK) begin
                        dec_state_nx = BRK;
                    end else begin
                        dec_state_nx = IDLE;
                    end
                end
                EXT:     dec_state_nx = (rx_byte == SC_BREAK) ? EXT_BRK : IDLE;
                BRK:     dec_state_nx = IDLE;
                EXT_BRK: dec_state_nx = IDLE;
                default: dec_state_nx = IDLE;
            endcase
        end
    end

    // Key levels are only ever set or cleared by a complete sequence; errors leave them alone.
    always_comb begin
        space_nx = key_space;
        left_nx  = key_left;
        right_nx = key_right;
        if (byte_valid && !frame_err) begin
            case (dec_state)
                IDLE: begin
                    if (rx_byte == SC_SPACE) space_nx = 1'b1;
                end
                EXT: begin
                    if (rx_byte == SC_LEFT)  left_nx  = 1'b1;
                    if (rx_byte == SC_RIGHT) right_nx = 1'b1;
                end
                BRK: begin
                    if (rx_byte == SC_SPACE) space_nx = 1'b0;
                end
                EXT_BRK: begin
                    if (rx_byte == SC_LEFT)  left_nx  = 1'b0;
                    if (rx_byte == SC_RIGHT) right_nx = 1'b0;
                end
                default: begin
                    space_nx = key_space;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_space <= 1'b0;
            key_left  <= 1'b0;
            key_right <= 1'b0;
        end else begin
            key_space <= space_nx;
            key_left  <= left_nx;
            key_right <= right_nx;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: table of directed frames, hand-written corner sequences,
// and random frames checked against a sequence-matching key model.
module tb_ps2_key_decoder;

    localparam int HALF = 25;

    logic clk;
    logic rst_n;
    logic ps2_clk;
    logic ps2_data;
    logic key_space;
    logic key_left;
    logic key_right;
    logic frame_err;

    ps2_key_decoder #(
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_space(key_space),
        .key_left (key_left),
        .key_right(key_right),
        .frame_err(frame_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got running, need finished");
        $fatal(1, "watchdog");
    end

    // ---------------- monitors ----------------
    int   err_cnt     = 0;
    int   long_pulse  = 0;
    logic err_prev    = 1'b0;
    int   last_fall   = 0;
    int   sp_rise_cyc = -1;
    logic sp_prev     = 1'b0;
    logic watch_space = 1'b0;
    int   space_drops = 0;

    always @(negedge clk) begin
        if (frame_err) err_cnt++;
        if (frame_err && err_prev) long_pulse++;
        err_prev = frame_err;
        if (key_space && !sp_prev && sp_rise_cyc < 0) sp_rise_cyc = cyc;
        sp_prev = key_space;
        if (watch_space && !key_space) space_drops++;
    end

    // ---------------- reference model ----------------
    logic [7:0] pend[$];
    logic       m_sp, m_lf, m_rt;
    int         exp_err = 0;
    logic [2:0] exp_q[$];

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0 && pend.size() == 0) begin
            pend.push_back(b);
        end else if (b == 8'hF0 && (pend.size() == 0 || (pend.size() == 1 && pend[0] == 8'hE0))) begin
            pend.push_back(b);
        end else begin
            if (pend.size() == 0) begin
                if (b == 8'h29) m_sp = 1'b1;
            end else if (pend.size() == 1 && pend[0] == 8'hF0) begin
                if (b == 8'h29) m_sp = 1'b0;
            end else if (pend.size() == 1) begin
                if (b == 8'h6B) m_lf = 1'b1;
                if (b == 8'h74) m_rt = 1'b1;
            end else begin
                if (b == 8'h6B) m_lf = 1'b0;
                if (b == 8'h74) m_rt = 1'b0;
            end
            pend.delete();
        end
    endtask

    task automatic model_error();
        exp_err++;
        pend.delete();
    endtask

    task automatic model_reset();
        pend.delete();
        m_sp = 1'b0;
        m_lf = 1'b0;
        m_rt = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk   = 1'b0;
        last_fall = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par);
        logic [10:0] bits;
        bits = {1'b1, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        if (bad_par) model_error();
        else model_byte(code);
        exp_q.push_back({m_sp, m_lf, m_rt});
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(input string nm);
        logic [2:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: expected queue empty, got nothing to compare", nm);
        end else begin
            e = exp_q.pop_front();
            chk(nm, int'({key_space, key_left, key_right}), int'(e));
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        logic [2:0] keys;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int err_before;
        int lat;

        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        chk("reset_keys", int'({key_space, key_left, key_right}), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // {code, bad parity, {space,left,right}, frame_err pulse}
        vecs.push_back('{8'h29, 1'b0, 3'b100, 1'b0});
        vecs.push_back('{8'hF0, 1'b0, 3'b100, 1'b0});
        vecs.push_back('{8'h29, 1'b0, 3'b000, 1'b0});
        vecs.push_back('{8'hE0, 1'b0, 3'b000, 1'b0});
        vecs.push_back('{8'h6B, 1'b0, 3'b010, 1'b0});
        vecs.push_back('{8'hE0, 1'b0, 3'b010, 1'b0});
        vecs.push_back('{8'h74, 1'b0, 3'b011, 1'b0});
        vecs.push_back('{8'hE0, 1'b0, 3'b011, 1'b0});
        vecs.push_back('{8'hF0, 1'b0, 3'b011, 1'b0});
        vecs.push_back('{8'h6B, 1'b0, 3'b001, 1'b0});
        vecs.push_back('{8'hE0, 1'b0, 3'b001, 1'b0});
        vecs.push_back('{8'hF0, 1'b0, 3'b001, 1'b0});
        vecs.push_back('{8'h74, 1'b0, 3'b000, 1'b0});
        vecs.push_back('{8'h6B, 1'b0, 3'b000, 1'b0});
        vecs.push_back('{8'hE0, 1'b0, 3'b000, 1'b0});
        vecs.push_back('{8'h6B, 1'b0, 3'b010, 1'b0});
        vecs.push_back('{8'hE0, 1'b0, 3'b010, 1'b0});
        vecs.push_back('{8'hF0, 1'b0, 3'b010, 1'b0});
        vecs.push_back('{8'h6B, 1'b0, 3'b000, 1'b0});
        vecs.push_back('{8'h74, 1'b0, 3'b000, 1'b0});
        vecs.push_back('{8'h29, 1'b1, 3'b000, 1'b1});
        vecs.push_back('{8'h29, 1'b0, 3'b100, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            err_before = err_cnt;
            send_frame(vecs[i].code, vecs[i].bad_par);
            chk($sformatf("vec%0d_keys", i), int'({key_space, key_left, key_right}), int'(vecs[i].keys));
            chk($sformatf("vec%0d_err", i), err_cnt - err_before, int'(vecs[i].err));
            check_model($sformatf("vec%0d_model", i));
            if (i == 0) begin
                lat = sp_rise_cyc - last_fall;
                n_cmp++;
                if (sp_rise_cyc < 0 || lat < 11 || lat > 13) begin
                    n_fail++;
                    $display("FAIL space_latency: got %0d cycles, expected 11..13", lat);
                end
            end
        end

        // Short ps2_clk glitch must be rejected by the filter.
        err_before = err_cnt;
        ps2_clk = 1'b0;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_err", err_cnt - err_before, 0);
        chk("glitch_keys", int'({key_space, key_left, key_right}), 3'b100);

        // Stall mid-frame past the timeout, then a full frame must still align.
        err_before = err_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (1200) @(negedge clk);
        model_error();
        chk("timeout_err", err_cnt - err_before, 1);
        send_frame(8'hF0, 1'b0);
        check_model("after_timeout_f0");
        send_frame(8'h29, 1'b0);
        check_model("after_timeout_break");
        chk("after_timeout_space", int'(key_space), 0);
        send_frame(8'h29, 1'b0);
        check_model("after_timeout_make");

        // Asynchronous reset mid-frame while left is held.
        send_frame(8'hE0, 1'b0);
        check_model("pre_reset_e0");
        send_frame(8'h6B, 1'b0);
        chk("pre_reset_left", int'(key_left), 1);
        check_model("pre_reset_model");
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({key_space, key_left, key_right, frame_err}), 0);
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
        model_reset();
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'hE0, 1'b0);
        check_model("post_reset_e0");
        send_frame(8'h74, 1'b0);
        chk("post_reset_keys", int'({key_space, key_left, key_right}), 3'b001);
        check_model("post_reset_model");

        // Typematic repeat of Space: level must never dip.
        send_frame(8'h29, 1'b0);
        check_model("repeat_first");
        watch_space = 1'b1;
        for (int r = 0; r < 4; r++) begin
            send_frame(8'h29, 1'b0);
            check_model($sformatf("repeat_%0d", r));
        end
        watch_space = 1'b0;
        chk("repeat_no_glitch", space_drops, 0);

        // Random frames against the model.
        for (int k = 0; k < 40; k++) begin
            logic [7:0] code;
            logic       bad;
            int         pick;
            pick = $urandom_range(0, 9);
            bad  = 1'b0;
            case (pick)
                0, 1:    code = 8'hE0;
                2, 3:    code = 8'hF0;
                4, 9:    code = 8'h29;
                5:       code = 8'h6B;
                6:       code = 8'h74;
                7:       code = 8'($urandom_range(0, 255));
                default: begin
                    code = 8'($urandom_range(0, 255));
                    bad  = 1'b1;
                end
            endcase
            send_frame(code, bad);
            check_model($sformatf("rand%0d_%02h", k, code));
        end

        chk("total_frame_err", err_cnt, exp_err);
        chk("frame_err_single_cycle", long_pulse, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
